// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the CPU fetch (IF) and data (DM) ports as a request/ack
// master, returning a one-cycle ack with registered data and stalling the CPU while access is pending.
module unified_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_rd_i,
   input  logic              dm_wr_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              err_o
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_DM, S_RESP} state_e;

   state_e            state_q;
   logic              mem_req_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              if_ack_q, dm_ack_q, err_q;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
   logic [TW-1:0]     tmo_cnt_q;
   logic [SW-1:0]     starve_cnt_q, starve_d;
   logic              grant_if_d, grant_dm_d;
   logic              dm_pend;
   logic              finish;
   logic [DATA_W-1:0] resp_data;

   assign dm_pend = dm_rd_i | dm_wr_i;

   // An access finishes on the memory ack or on its last allowed cycle; an ack in that cycle still wins.
   assign finish    = mem_ack_i | (tmo_cnt_q == TMO_LAST);
   assign resp_data = mem_ack_i ? mem_rdata_i : '0;

   always_comb begin
      // NOTE: every combinational output is assigned a default first so no latch is inferred.
      grant_if_d = 1'b0;
      grant_dm_d = 1'b0;
      starve_d   = starve_cnt_q;
      if (dm_pend && (starve_cnt_q < STARVE_LIM)) begin
         grant_dm_d = 1'b1;
      end else if (if_req_i) begin
         grant_if_d = 1'b1;
      end else if (dm_pend) begin
         grant_dm_d = 1'b1;
      end
      if (!if_req_i || grant_if_d) begin
         starve_d = '0;
      end else if (grant_dm_d && (starve_cnt_q != STARVE_LIM)) begin
         starve_d = starve_cnt_q + SW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the data registers are cleared as well, so every registered output reads 0 after reset.
         state_q      <= S_IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_ack_q     <= 1'b0;
         dm_ack_q     <= 1'b0;
         err_q        <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         tmo_cnt_q    <= '0;
         starve_cnt_q <= '0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               starve_cnt_q <= starve_d;
               tmo_cnt_q    <= '0;
               if (grant_dm_d) begin
                  state_q     <= S_BUSY_DM;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= dm_wr_i;
                  mem_addr_q  <= dm_addr_i;
                  mem_wdata_q <= dm_wdata_i;
               end else if (grant_if_d) begin
                  state_q    <= S_BUSY_IF;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= if_addr_i;
               end
            end
            S_BUSY_IF, S_BUSY_DM: begin
               if (finish) begin
                  state_q   <= S_RESP;
                  mem_req_q <= 1'b0;
                  err_q     <= ~mem_ack_i;
                  if (state_q == S_BUSY_IF) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= resp_data;
                  end else begin
                     dm_ack_q <= 1'b1;
                     if (!mem_we_q) dm_rdata_q <= resp_data;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TW'(1);
               end
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign if_ack_o    = if_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_ack_o    = dm_ack_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign err_o       = err_q;
   assign stall_o     = (if_req_i & ~if_ack_q) | (dm_pend & ~dm_ack_q);

endmodule
